// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int MEM_WAIT_DEFAULT = 3;

  // A lone requester always wins; on a tie the side that did not win last time goes.
  function automatic owner_t pick_owner(input logic i_req, input logic d_req,
                                        input owner_t last_grant);
    if (i_req && d_req) return (last_grant == OWN_I) ? OWN_D : OWN_I;
    return d_req ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one off-chip memory between I and D sides.
// Define MEM_ARB_PERF_EN to add the saturating conflict_cnt output.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = MEM_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_oe,
  input  logic [15:0] mem_rdata,
  output logic        busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  owner_t     owner;
  owner_t     last_grant;
  owner_t     grant;
  logic [3:0] cnt;
  logic       lat_we;
  logic       any_req;
  logic       last_beat;

  assign any_req   = i_req | d_req;
  assign grant     = pick_owner(i_req, d_req, last_grant);
  assign last_beat = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The request is captured once at grant so requester changes cannot disturb the transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_I;
      last_grant <= OWN_D;
      cnt        <= '0;
      lat_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= grant;
            cnt   <= '0;
            if (grant == OWN_D) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              lat_we    <= d_we;
            end else begin
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              lat_we    <= 1'b0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (last_beat && !lat_we) begin
            if (owner == OWN_I) i_rdata <= mem_rdata;
            else                d_rdata <= mem_rdata;
          end
        end
        DONE:    last_grant <= owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_oe = 1'b0;
    i_ack  = 1'b0;
    d_ack  = 1'b0;
    busy   = (state != IDLE);
    case (state)
      ACCESS: begin
        mem_we = lat_we;
        mem_oe = ~lat_we;
      end
      DONE: begin
        i_ack = (owner == OWN_I);
        d_ack = (owner == OWN_D);
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_cnt <= '0;
    else if (state == IDLE && i_req && d_req && conflict_cnt != 16'hFFFF)
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int W = MEM_WAIT_DEFAULT;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_ack, d_ack, mem_we, mem_oe, busy;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] conflict_cnt;
  logic [15:0] w1_conflict_cnt;
`endif

  logic        w1_i_req, w1_d_req;
  logic [15:0] w1_i_rdata, w1_d_rdata, w1_mem_addr, w1_mem_wdata;
  logic        w1_i_ack, w1_d_ack, w1_mem_we, w1_mem_oe, w1_busy;

  logic [15:0] bench_mem [16];
  logic [15:0] model_mem [16];
  logic        use_fixed;
  logic [15:0] fixed_rdata;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign mem_rdata = use_fixed ? fixed_rdata : bench_mem[mem_addr[3:0]];

  always @(posedge clk)
    if (mem_we) bench_mem[mem_addr[3:0]] <= mem_wdata;

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  mem_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .i_req(w1_i_req), .i_addr(16'h0001), .i_rdata(w1_i_rdata), .i_ack(w1_i_ack),
    .d_req(w1_d_req), .d_we(1'b0), .d_addr(16'h0002), .d_wdata(16'h0000),
    .d_rdata(w1_d_rdata), .d_ack(w1_d_ack),
    .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata), .mem_we(w1_mem_we), .mem_oe(w1_mem_oe),
    .mem_rdata(16'h7777), .busy(w1_busy)
`ifdef MEM_ARB_PERF_EN
    , .conflict_cnt(w1_conflict_cnt)
`endif
  );

  typedef struct {
    logic        side;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] memdata;
    logic [15:0] exp_rdata;
    logic        exp_we;
    logic [15:0] exp_mem_wdata;
  } vec_t;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Leaves the bench at the falling edge of the first IDLE cycle after reset.
  task automatic doReset();
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; w1_i_req = 1'b0; w1_d_req = 1'b0;
    d_we = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int          acc_cycles = 0;
    int          ack_at     = -1;
    logic [15:0] rdata;
    use_fixed   = 1'b1;
    fixed_rdata = v.memdata;
    i_addr = v.addr; d_addr = v.addr; d_wdata = v.wdata; d_we = v.we;
    if (v.side) d_req = 1'b1;
    else        i_req = 1'b1;
    for (int k = 1; k <= W + 4 && ack_at < 0; k++) begin
      @(negedge clk);
      if (k == 2) begin
        i_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata; d_we = ~v.we;
      end
      if (mem_oe || mem_we) begin
        acc_cycles++;
        checkOutput("access_addr", mem_addr, v.addr);
        checkOutput("access_we", 16'(mem_we), 16'(v.exp_we));
        checkOutput("access_wdata", mem_wdata, v.exp_mem_wdata);
      end
      checkOutput("ack_overlap", 16'(i_ack & d_ack), 16'h0);
      if (i_ack || d_ack) begin
        ack_at = k;
        checkOutput("ack_side", 16'(d_ack), 16'(v.side));
        rdata = v.side ? d_rdata : i_rdata;
        checkOutput("ack_rdata", rdata, v.exp_rdata);
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    checkOutput("ack_latency", 16'(ack_at), 16'(W + 1));
    checkOutput("access_cycles", 16'(acc_cycles), 16'(W));
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", 16'(busy), 16'h0);
    checkOutput("idle_oe_we", 16'({mem_oe, mem_we}), 16'h0);
    checkOutput("idle_addr_hold", mem_addr, v.addr);
  endtask

  task automatic runTable();
    vec_t vecs[7];
    vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0100, 16'h9999, 16'h1357, 16'h1357, 1'b0, 16'h9999};
    vecs[2] = '{1'b1, 1'b1, 16'h1234, 16'h5A5A, 16'hDEAD, 16'h1357, 1'b1, 16'h5A5A};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 16'hA5A5, 16'h1234, 16'h0F0F, 16'h0F0F, 1'b0, 16'h0000};
    vecs[6] = '{1'b0, 1'b1, 16'h0777, 16'h4321, 16'h2468, 16'h2468, 1'b0, 16'h0000};
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);
  endtask

  task automatic runConflict();
    int i_at = -1;
    int d_at = -1;
    doReset();
    use_fixed = 1'b1; fixed_rdata = 16'hA1A1;
    i_addr = 16'h0011; d_addr = 16'h0022; d_we = 1'b0; d_wdata = 16'h0000;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 2 * W + 6; k++) begin
      @(negedge clk);
      if (k == 1)     checkOutput("conf_first_addr", mem_addr, 16'h0011);
      if (k == W + 2) checkOutput("conf_gap_busy", 16'(busy), 16'h0);
      if (k == W + 3) checkOutput("conf_second_addr", mem_addr, 16'h0022);
      checkOutput("conf_ack_overlap", 16'(i_ack & d_ack), 16'h0);
      if (i_ack) begin i_at = k; i_req = 1'b0; end
      if (d_ack) begin d_at = k; d_req = 1'b0; end
    end
    checkOutput("conf_i_ack_cycle", 16'(i_at), 16'(W + 1));
    checkOutput("conf_d_ack_cycle", 16'(d_at), 16'(2 * W + 3));
    checkOutput("conf_i_rdata", i_rdata, 16'hA1A1);
    checkOutput("conf_d_rdata", d_rdata, 16'hA1A1);
`ifdef MEM_ARB_PERF_EN
    checkOutput("conf_count", conflict_cnt, 16'd1);
`endif
  endtask

  // Reset lands at cnt == 1 of a D read; rdata registers hold A1A1 from the previous test.
  task automatic runMidReset();
    int   acks = 0;
    vec_t v;
    use_fixed = 1'b1; fixed_rdata = 16'h3333;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050; d_wdata = 16'h00AA;
    repeat (2) @(negedge clk);
    checkOutput("mid_oe_before", 16'(mem_oe), 16'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_oe_async", 16'(mem_oe), 16'h0);
    checkOutput("mid_busy", 16'(busy), 16'h0);
    checkOutput("mid_addr", mem_addr, 16'h0000);
    checkOutput("mid_wdata", mem_wdata, 16'h0000);
    checkOutput("mid_i_rdata", i_rdata, 16'h0000);
    checkOutput("mid_d_rdata", d_rdata, 16'h0000);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (i_ack || d_ack) acks++;
    end
    checkOutput("mid_no_ack", 16'(acks), 16'h0);
    v = '{1'b1, 1'b0, 16'h0060, 16'h0000, 16'h4444, 16'h4444, 1'b0, 16'h0000};
    applyStimulus(v);
  endtask

  task automatic runW1();
    int   cyc_at[4];
    logic side_at[4];
    int   n = 0;
    for (int i = 0; i < 4; i++) begin cyc_at[i] = -1; side_at[i] = 1'b0; end
    doReset();
    w1_i_req = 1'b1; w1_d_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checkOutput("w1_overlap", 16'(w1_i_ack & w1_d_ack), 16'h0);
      if ((w1_i_ack || w1_d_ack) && n < 4) begin
        cyc_at[n]  = k;
        side_at[n] = w1_d_ack;
        checkOutput("w1_rdata", w1_d_ack ? w1_d_rdata : w1_i_rdata, 16'h7777);
        n++;
      end
    end
    w1_i_req = 1'b0; w1_d_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("w1_ack_cycle", 16'(cyc_at[i]), 16'(2 + 3 * i));
      checkOutput("w1_ack_side", 16'(side_at[i]), 16'(i % 2));
    end
  endtask

  // Reference: one transfer at a time; a grant at cycle g occupies g+1..g+W, acks at g+W+1,
  // and the arbiter can grant again from g+W+2. Memory contents are tracked per transfer.
  task automatic runRandom();
    int          m_g = -100;
    logic        m_own = 1'b0;
    logic        m_last = 1'b1;
    logic        m_we = 1'b0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_i_rdata = '0, m_d_rdata = '0;
    logic        in_acc, ack_cyc;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] m_conf = '0;
`endif
    doReset();
    use_fixed = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bench_mem[i] = 16'(i * 16'h1111) ^ 16'h0F0F;
      model_mem[i] = 16'(i * 16'h1111) ^ 16'h0F0F;
    end
    for (int n = 0; n < 2000; n++) begin
      in_acc  = (n > m_g) && (n <= m_g + W);
      ack_cyc = (n == m_g + W + 1);
      checkOutput("rnd_busy", 16'(busy), 16'((n > m_g) && (n <= m_g + W + 1)));
      checkOutput("rnd_oe", 16'(mem_oe), 16'(in_acc && !m_we));
      checkOutput("rnd_we", 16'(mem_we), 16'(in_acc && m_we));
      checkOutput("rnd_i_ack", 16'(i_ack), 16'(ack_cyc && !m_own));
      checkOutput("rnd_d_ack", 16'(d_ack), 16'(ack_cyc && m_own));
      checkOutput("rnd_addr", mem_addr, m_addr);
      checkOutput("rnd_wdata", mem_wdata, m_wdata);
      if (ack_cyc) begin
        if (m_own) checkOutput("rnd_d_rdata", d_rdata, m_d_rdata);
        else       checkOutput("rnd_i_rdata", i_rdata, m_i_rdata);
      end
`ifdef MEM_ARB_PERF_EN
      checkOutput("rnd_conflicts", conflict_cnt, m_conf);
`endif
      if (i_ack) i_req = 1'b0;
      else if (!i_req && $urandom_range(2) == 0) begin
        i_req = 1'b1; i_addr = 16'($urandom);
      end
      if (d_ack) d_req = 1'b0;
      else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if (n >= m_g + W + 2 && (i_req || d_req)) begin
        if (i_req && d_req) begin
          m_own = ~m_last;
`ifdef MEM_ARB_PERF_EN
          if (m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
`endif
        end else begin
          m_own = d_req;
        end
        m_g    = n;
        m_last = m_own;
        if (m_own) begin m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; end
        else       begin m_we = 1'b0; m_addr = i_addr; m_wdata = 16'h0000; end
        if (m_we)      model_mem[m_addr[3:0]] = m_wdata;
        else if (m_own) m_d_rdata = model_mem[m_addr[3:0]];
        else            m_i_rdata = model_mem[m_addr[3:0]];
      end
      @(negedge clk);
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    use_fixed   = 1'b1;
    fixed_rdata = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      bench_mem[i] = '0;
      model_mem[i] = '0;
    end
    doReset();
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_acks", 16'({i_ack, d_ack}), 16'h0);
    checkOutput("rst_oe_we", 16'({mem_oe, mem_we}), 16'h0);
    checkOutput("rst_mem_addr", mem_addr, 16'h0000);
    checkOutput("rst_mem_wdata", mem_wdata, 16'h0000);
    checkOutput("rst_i_rdata", i_rdata, 16'h0000);
    checkOutput("rst_d_rdata", d_rdata, 16'h0000);
`ifdef MEM_ARB_PERF_EN
    checkOutput("rst_conflicts", conflict_cnt, 16'h0000);
`endif
    runTable();
    runConflict();
    runMidReset();
    runW1();
    runRandom();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 3: off-chip memory access cycles per transfer, legal range 1..15.
REQ-002 Port clk  in  1  single clock; all state updates on posedge clk.
REQ-003 Port rst  in  1  asynchronous, active-high reset.
REQ-004 Port i_req  in  1  instruction-side refill request, held until i_ack.
REQ-005 Port i_addr  in  16  instruction-side word address.
REQ-006 Port i_rdata  out  16  instruction-side read data, valid while i_ack is high.
REQ-007 Port i_ack  out  1  one-cycle completion pulse, instruction side.
REQ-008 Port d_req  in  1  data-side request, held until d_ack.
REQ-009 Port d_we  in  1  data-side write (1) / read (0).
REQ-010 Port d_addr  in  16  data-side word address.
REQ-011 Port d_wdata  in  16  data-side store data.
REQ-012 Port d_rdata  out  16  data-side read data, valid while d_ack is high.
REQ-013 Port d_ack  out  1  one-cycle completion pulse, data side.
REQ-014 Port mem_addr  out  16  registered off-chip address.
REQ-015 Port mem_wdata  out  16  registered off-chip write data.
REQ-016 Port mem_we  out  1  off-chip write enable.
REQ-017 Port mem_oe  out  1  off-chip output enable.
REQ-018 Port mem_rdata  in  16  off-chip read data.
REQ-019 Port busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, ACCESS, DONE; counter cnt is 4 bits wide.
REQ-021 IDLE transition: any req high -> ACCESS; latch owner, address, we, and wdata (wdata = 0 and we = 0 for the I side); cnt <= 0.
REQ-022 Single request: that request is granted.
REQ-023 Simultaneous i_req and d_req: grant the side not recorded in last_grant (round robin).
REQ-024 ACCESS: mem_we = latched we, mem_oe = ~latched we, held for exactly WAIT_CYCLES cycles; cnt increments once per cycle.
REQ-025 ACCESS exit: when cnt == WAIT_CYCLES-1, a read captures mem_rdata into the owner's rdata register, then state -> DONE.
REQ-026 DONE: owner's ack is high for exactly one cycle; last_grant <= owner; state -> IDLE.
REQ-027 Latency: a request sampled in IDLE at cycle 0 acks at cycle WAIT_CYCLES+1; back-to-back transfers cost WAIT_CYCLES+2 cycles each.
REQ-028 Handshake: a requester deasserts req on the edge ending its ack cycle; a req still high in the following IDLE is treated as a new request.
REQ-029 Writes assert d_ack but leave d_rdata unchanged.
REQ-030 Outside ACCESS: mem_we = mem_oe = 0; mem_addr and mem_wdata hold their last latched values.
REQ-031 Changes on req/addr/wdata during ACCESS or DONE have no effect on the transfer in flight.
REQ-032 i_ack and d_ack are never high in the same cycle.

Reset
REQ-033 rst asserted at any time, including mid-ACCESS, immediately forces: state IDLE, cnt 0, mem_we 0, mem_oe 0, i_ack 0, d_ack 0, busy 0, mem_addr 0, mem_wdata 0, i_rdata 0, d_rdata 0, last_grant = D (I side wins the first tie).
REQ-034 A transfer interrupted by reset is dropped and never acknowledged.

Configuration
REQ-035 Macro MEM_ARB_PERF_EN defined: adds output conflict_cnt (16 bits), incremented on each IDLE cycle where both reqs are high and a grant is made; saturates at 16'hFFFF; reset value 0.
REQ-036 Macro MEM_ARB_PERF_EN undefined: conflict_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-037 Shared package mem_arb_pkg holds: the state encoding (IDLE/ACCESS/DONE), owner encoding (OWN_I = 0, OWN_D = 1), and constant MEM_WAIT_DEFAULT = 3.
REQ-038 No sub-module; round-robin pick and counter are implemented in-line.

Verification
REQ-039 Reset, then i_req with i_addr=16'h0040, mem_rdata=16'hBEEF -> mem_oe high cycles 1-3, i_ack at cycle 4 with i_rdata=16'hBEEF.
REQ-040 i_req and d_req both high in the first IDLE after reset -> I granted first; D granted next with no intervening idle cycle beyond IDLE; with PERF, conflict_cnt=1.
REQ-041 d_req, d_we=1, d_addr=16'h1234, d_wdata=16'h5A5A -> mem_we high 3 cycles with mem_addr=16'h1234, mem_wdata=16'h5A5A; d_ack pulses; d_rdata unchanged.
REQ-042 rst asserted at cnt=1 of a D read -> mem_oe drops asynchronously; no d_ack; a subsequent request completes normally.
REQ-043 WAIT_CYCLES=1, continuous i_req and d_req -> acks alternate I, D, I, D at 3-cycle spacing.
